alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one ALU datapath (the OR/AND/ADD/shift units of the SHA processor ALU) between NREQ requesters, such as the message-schedule and compression-round sequencers.
- Arbitrates round-robin, registers the chosen operands onto the ALU inputs and waits a fixed ALU latency.
- Captures the result and returns it to the requester with the requester ID, over a valid/ready response channel.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 32, operand/result width
OPW, 3, ALU opcode width (opcode passed through unchanged)
LAT, 1, ALU pipeline depth in cycles from alu_* inputs to alu_res (0..7)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_op  in  NREQ*OPW  opcodes; requester i at [i*OPW +: OPW]
req_a  in  NREQ*W  operand A; requester i at [i*W +: W]
req_b  in  NREQ*W  operand B; same packing
alu_op  out  OPW  registered opcode to ALU
alu_a  out  W  registered operand A to ALU
alu_b  out  W  registered operand B to ALU
alu_res  in  W  ALU result
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  $clog2(NREQ)  index of requester that owns rsp_data
rsp_data  out  W  captured result
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE; alu_op/alu_a/alu_b=0; rsp_valid=0; rsp_id=0; rsp_data=0; latency counter=0; last_grant=NREQ-1, so requester 0 wins first. While rst is high, req_ready=0.
- States are IDLE, EXEC and RESP.
- IDLE:
  - grant g is the first i with req_valid[i]=1, searching last_grant+1, +2, … modulo NREQ.
  - req_ready[g]=1 combinationally; all other bits are 0. No req_valid means req_ready=0 and the block stays in IDLE.
  - At the accept edge: alu_op/a/b <= requester g fields; rsp_id <= g; last_grant <= g; counter <= LAT; go to EXEC.
- EXEC:
  - lasts LAT+1 cycles. Each cycle with counter!=0 decrements the counter.
  - At the edge ending the cycle with counter==0: rsp_data <= alu_res; go to RESP.
  - alu_* are held stable for the whole of EXEC and RESP.
- RESP:
  - rsp_valid=1. rsp_id and rsp_data are held stable until rsp_ready=1.
  - On the handshake edge, go to IDLE with rsp_valid=0.
  - No new request is accepted in the same cycle as a response handshake.
- Timing: accept in cycle c means EXEC in c+1..c+1+LAT and rsp_valid first high in cycle c+2+LAT. Peak throughput is one op per LAT+3 cycles.
- req_ready is only ever high in IDLE. A requester must hold valid and fields stable until it sees ready. A requester that drops valid before grant is simply skipped; this is not an error.
- alu_* keep their last values in IDLE; they are not cleared after a transaction.
- Reset in EXEC or RESP abandons the transaction: no response is issued and the pointer returns to NREQ-1.
- Simultaneous requests: exactly one is granted per IDLE visit, by round-robin. A continuously requesting requester waits at most NREQ-1 transactions.
- Width rules: rsp_data is exactly alu_res (W bits, no extension). The opcode is not interpreted.

Test Plan:
- Bench ALU model computes a|b for op=3'b001 through LAT register stages.
- Single request, LAT=1: req 2 sends op=001, a=0x5, b=0x4 in cycle 0 -> req_ready=0100 in cycle 0; alu_a=0x5 from cycle 1; rsp_valid in cycle 3 with rsp_id=2, rsp_data=0x5; busy high cycles 1-3.
- All four request continuously with a=i, b=0x10, rsp_ready=1 -> grant order 0,1,2,3,0,1; responses 0x10,0x11,0x12,0x13,0x10,0x11; accepts every 4 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_valid, rsp_id and rsp_data are held; req_ready=0 throughout; next accept occurs the cycle after the handshake.
- Latency sweep: LAT=0 gives rsp_valid at c+2; LAT=3 gives it at c+5. alu_* are stable over the whole window, and the data matches a|b of the accepted request (a=0x6, b=0x5 -> 0x7).
- Reset mid-EXEC: rst=1 for one cycle during EXEC -> next cycle has rsp_valid=0, busy=0, all outputs 0. With req 1 and req 3 pending afterwards, req 1 is granted first.
- Requester 1 raises valid, then drops it while req 0 is being served; req 3 is also pending -> req 3 is granted next, req 1 is never granted and no response has rsp_id=1.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU datapath between NREQ requesters.
// Round-robin arbitration in IDLE, registered operands to the ALU, a fixed
// LAT-cycle wait in EXEC, then the captured result is offered on a
// valid/ready response channel tagged with the owning requester ID.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_op/req_a/req_b    packed per-requester opcode and operands
//   alu_op/alu_a/alu_b    registered ALU inputs, held from accept to next accept
//   alu_res               ALU result, valid LAT cycles after the alu_* inputs
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/rsp_data       owner of the response and the captured result
//   busy                  high whenever a transaction is in flight
module alu_share_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 32,
  parameter int unsigned OPW  = 3,
  parameter int unsigned LAT  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*OPW-1:0]     req_op,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  output logic [OPW-1:0]          alu_op,
  output logic [W-1:0]            alu_a,
  output logic [W-1:0]            alu_b,
  input  logic [W-1:0]            alu_res,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [W-1:0]            rsp_data,
  output logic                    busy
);

  localparam int unsigned IDW = $clog2(NREQ);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [2:0] LatC = 3'(LAT);

  logic [1:0]     state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;

  // Round-robin search starting just after the last grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_grant_q) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Grants are offered only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && !rst && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    case (state_q)
      StIdle: begin
        if (grant_found) begin
          alu_op_d     = req_op[32'(grant_idx) * OPW +: OPW];
          alu_a_d      = req_a[32'(grant_idx) * W +: W];
          alu_b_d      = req_b[32'(grant_idx) * W +: W];
          rsp_id_d     = grant_idx;
          last_grant_d = grant_idx;
          cnt_d        = LatC;
          state_d      = StExec;
        end
      end
      StExec: begin
        // Counter runs LAT..0, giving LAT+1 EXEC cycles; capture on the zero cycle.
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          rsp_data_d = alu_res;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      last_grant_q <= IDW'(NREQ - 1);
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of alu_share_arbiter.
// Three instances share the clock and reset: LAT=1 (main), LAT=0 and LAT=3.
module tb_alu_share_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 32;
  localparam int unsigned OPW  = 3;
  localparam int unsigned IDW  = 2;
  localparam int unsigned NI   = 3;

  logic clk = 1'b0;
  logic rst;

  logic [NREQ-1:0]     req_valid [NI];
  logic [NREQ-1:0]     req_ready [NI];
  logic [NREQ*OPW-1:0] req_op    [NI];
  logic [NREQ*W-1:0]   req_a     [NI];
  logic [NREQ*W-1:0]   req_b     [NI];
  logic [OPW-1:0]      alu_op    [NI];
  logic [W-1:0]        alu_a     [NI];
  logic [W-1:0]        alu_b     [NI];
  logic [W-1:0]        alu_res   [NI];
  logic                rsp_valid [NI];
  logic                rsp_ready [NI];
  logic [IDW-1:0]      rsp_id    [NI];
  logic [W-1:0]        rsp_data  [NI];
  logic                busy      [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    if (op == 3'b001) return a | b;
    if (op == 3'b010) return a & b;
    return a + b;
  endfunction

  for (genvar u = 0; u < NI; u++) begin : g_dut
    localparam int unsigned L = (u == 0) ? 1 : ((u == 1) ? 0 : 3);
    alu_share_arbiter #(.NREQ(NREQ), .W(W), .OPW(OPW), .LAT(L)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[u]),
      .req_ready(req_ready[u]),
      .req_op   (req_op[u]),
      .req_a    (req_a[u]),
      .req_b    (req_b[u]),
      .alu_op   (alu_op[u]),
      .alu_a    (alu_a[u]),
      .alu_b    (alu_b[u]),
      .alu_res  (alu_res[u]),
      .rsp_valid(rsp_valid[u]),
      .rsp_ready(rsp_ready[u]),
      .rsp_id   (rsp_id[u]),
      .rsp_data (rsp_data[u]),
      .busy     (busy[u])
    );
    if (L == 0) begin : g_comb
      assign alu_res[u] = alu_f(alu_op[u], alu_a[u], alu_b[u]);
    end else begin : g_pipe
      logic [W-1:0] pipe [L];
      always @(posedge clk) begin
        pipe[0] <= alu_f(alu_op[u], alu_a[u], alu_b[u]);
        for (int s = 1; s < int'(L); s++) pipe[s] <= pipe[s-1];
      end
      assign alu_res[u] = pipe[L-1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_all();
    for (int u = 0; u < int'(NI); u++) begin
      req_valid[u] = '0;
      req_op[u]    = '0;
      req_a[u]     = '0;
      req_b[u]     = '0;
      rsp_ready[u] = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int u, input int i, input logic [OPW-1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[u][i]          = 1'b1;
    req_op[u][i*OPW +: OPW]  = op;
    req_a[u][i*W +: W]       = a;
    req_b[u][i*W +: W]       = b;
  endtask

  task automatic wait_rsp(input int u, input int bound);
    int n;
    n = 0;
    while (rsp_valid[u] !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk("rsp_wait", 64'(rsp_valid[u]), 64'd1);
  endtask

  // Transaction-level reference state for the randomized phase.
  bit             pend [NREQ];
  logic [OPW-1:0] mop  [NREQ];
  logic [W-1:0]   ma   [NREQ];
  logic [W-1:0]   mb   [NREQ];

  initial begin
    int n;
    int ptr;
    int g;
    int rsp_at;
    int exp_id;
    bit waiting;
    logic [W-1:0]    exp_data;
    logic [NREQ-1:0] exp_ready;

    // Reset: ready suppressed while rst high, all outputs cleared.
    idle_all();
    rst = 1'b1;
    req_valid[0] = 4'b1111;
    settle();
    chk("ready_in_rst", 64'(req_ready[0]), 64'd0);
    tick();
    settle();
    chk("rst_ready", 64'(req_ready[0]), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_alu_a", 64'(alu_a[0]), 64'd0);
    chk("rst_alu_op", 64'(alu_op[0]), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id[0]), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data[0]), 64'd0);
    rst = 1'b0;
    idle_all();

    // Single request from requester 2, LAT=1.
    set_req(0, 2, 3'b001, 32'h5, 32'h4);
    settle();
    chk("single_ready", 64'(req_ready[0]), 64'b0100);
    chk("single_busy_c0", 64'(busy[0]), 64'd0);
    tick();
    req_valid[0] = '0;
    settle();
    chk("single_alu_a", 64'(alu_a[0]), 64'h5);
    chk("single_busy_c1", 64'(busy[0]), 64'd1);
    chk("single_ready_c1", 64'(req_ready[0]), 64'd0);
    tick();
    chk("single_busy_c2", 64'(busy[0]), 64'd1);
    chk("single_valid_c2", 64'(rsp_valid[0]), 64'd0);
    tick();
    chk("single_valid_c3", 64'(rsp_valid[0]), 64'd1);
    chk("single_id", 64'(rsp_id[0]), 64'd2);
    chk("single_data", 64'(rsp_data[0]), 64'h5);
    chk("single_busy_c3", 64'(busy[0]), 64'd1);
    tick();
    chk("single_busy_c4", 64'(busy[0]), 64'd0);
    chk("single_alu_kept", 64'(alu_a[0]), 64'h5);

    // All four requesting continuously: grants 0,1,2,3,0,1 every 4 cycles.
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) set_req(0, i, 3'b001, 32'(i), 32'h10);
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("rr_ready", 64'(req_ready[0]), 64'(1 << (k % 4)));
      tick();
      tick();
      tick();
      chk("rr_valid", 64'(rsp_valid[0]), 64'd1);
      chk("rr_ready_resp", 64'(req_ready[0]), 64'd0);
      chk("rr_id", 64'(rsp_id[0]), 64'(k % 4));
      chk("rr_data", 64'(rsp_data[0]), 64'(32'h10 | 32'(k % 4)));
      tick();
    end
    idle_all();

    // Backpressure: last grant was 1, so req 2 beats req 0.
    set_req(0, 0, 3'b001, 32'h3, 32'h8);
    set_req(0, 2, 3'b001, 32'h20, 32'h1);
    rsp_ready[0] = 1'b0;
    settle();
    chk("bp_ready", 64'(req_ready[0]), 64'b0100);
    tick();
    req_valid[0][2] = 1'b0;
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 64'(rsp_valid[0]), 64'd1);
      chk("bp_id", 64'(rsp_id[0]), 64'd2);
      chk("bp_data", 64'(rsp_data[0]), 64'h21);
      chk("bp_ready_hold", 64'(req_ready[0]), 64'd0);
      tick();
    end
    rsp_ready[0] = 1'b1;
    settle();
    chk("bp_hs_valid", 64'(rsp_valid[0]), 64'd1);
    chk("bp_hs_noaccept", 64'(req_ready[0]), 64'd0);
    tick();
    chk("bp_next_accept", 64'(req_ready[0]), 64'b0001);
    tick();
    req_valid[0] = '0;
    wait_rsp(0, 10);
    chk("bp_id2", 64'(rsp_id[0]), 64'd0);
    chk("bp_data2", 64'(rsp_data[0]), 64'hB);
    tick();

    // Latency sweep on the LAT=0 and LAT=3 instances.
    for (int u = 1; u <= 2; u++) begin
      set_req(u, 0, 3'b001, 32'h6, 32'h5);
      settle();
      chk("lat_ready", 64'(req_ready[u]), 64'b0001);
      tick();
      req_valid[u] = '0;
      n = 1;
      while (rsp_valid[u] !== 1'b1 && n < 20) begin
        chk("lat_alu_a", 64'(alu_a[u]), 64'h6);
        chk("lat_alu_b", 64'(alu_b[u]), 64'h5);
        chk("lat_alu_op", 64'(alu_op[u]), 64'b001);
        tick();
        n++;
      end
      chk("lat_valid", 64'(rsp_valid[u]), 64'd1);
      chk("lat_cycles", 64'(n), (u == 1) ? 64'd2 : 64'd5);
      chk("lat_data", 64'(rsp_data[u]), 64'h7);
      chk("lat_alu_a_resp", 64'(alu_a[u]), 64'h6);
      tick();
    end

    // Reset during EXEC abandons the transaction and rewinds the pointer.
    set_req(0, 0, 3'b001, 32'h1, 32'h2);
    settle();
    chk("mid_ready", 64'(req_ready[0]), 64'b0001);
    tick();
    req_valid[0] = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("mid_valid", 64'(rsp_valid[0]), 64'd0);
    chk("mid_busy", 64'(busy[0]), 64'd0);
    chk("mid_alu_a", 64'(alu_a[0]), 64'd0);
    chk("mid_alu_b", 64'(alu_b[0]), 64'd0);
    chk("mid_rsp_id", 64'(rsp_id[0]), 64'd0);
    chk("mid_rsp_data", 64'(rsp_data[0]), 64'd0);
    set_req(0, 1, 3'b001, 32'h100, 32'h1);
    set_req(0, 3, 3'b001, 32'h300, 32'h3);
    settle();
    chk("mid_grant1", 64'(req_ready[0]), 64'b0010);
    tick();
    req_valid[0][1] = 1'b0;
    wait_rsp(0, 10);
    chk("mid_id1", 64'(rsp_id[0]), 64'd1);
    chk("mid_data1", 64'(rsp_data[0]), 64'h101);
    tick();
    chk("mid_grant3", 64'(req_ready[0]), 64'b1000);
    tick();
    req_valid[0] = '0;
    wait_rsp(0, 10);
    chk("mid_id3", 64'(rsp_id[0]), 64'd3);
    tick();

    // Requester 1 drops valid before its turn; req 3 must be served instead.
    do_reset();
    set_req(0, 0, 3'b001, 32'h40, 32'h2);
    settle();
    chk("drop_ready0", 64'(req_ready[0]), 64'b0001);
    tick();
    req_valid[0][0] = 1'b0;
    set_req(0, 1, 3'b001, 32'h11, 32'h0);
    set_req(0, 3, 3'b001, 32'h33, 32'h0);
    tick();
    req_valid[0][1] = 1'b0;
    wait_rsp(0, 10);
    chk("drop_id0", 64'(rsp_id[0]), 64'd0);
    chk("drop_data0", 64'(rsp_data[0]), 64'h42);
    tick();
    chk("drop_grant3", 64'(req_ready[0]), 64'b1000);
    tick();
    req_valid[0] = '0;
    wait_rsp(0, 10);
    chk("drop_id3", 64'(rsp_id[0]), 64'd3);
    tick();
    settle();
    chk("drop_no_req1", 64'(req_ready[0]), 64'd0);
    chk("drop_idle", 64'(busy[0]), 64'd0);

    // Randomized traffic against a transaction-level model (LAT=1 instance).
    idle_all();
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) pend[i] = 1'b0;
    ptr     = int'(NREQ) - 1;
    waiting = 1'b0;
    rsp_at  = 0;
    exp_id  = 0;
    exp_data = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          mop[i]  = OPW'($urandom_range(0, 3));
          ma[i]   = $urandom;
          mb[i]   = $urandom;
        end else if (pend[i] && !waiting && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end else if (pend[i] && waiting && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
        req_valid[0][i]         = pend[i];
        req_op[0][i*OPW +: OPW] = mop[i];
        req_a[0][i*W +: W]      = ma[i];
        req_b[0][i*W +: W]      = mb[i];
      end
      rsp_ready[0] = ($urandom_range(0, 3) != 0);
      settle();
      exp_ready = '0;
      chk("rnd_busy", 64'(busy[0]), 64'(waiting));
      if (waiting) begin
        if (cyc >= rsp_at) begin
          chk("rnd_valid", 64'(rsp_valid[0]), 64'd1);
          chk("rnd_id", 64'(rsp_id[0]), 64'(exp_id));
          chk("rnd_data", 64'(rsp_data[0]), 64'(exp_data));
          if (rsp_ready[0]) waiting = 1'b0;
        end else begin
          chk("rnd_valid_early", 64'(rsp_valid[0]), 64'd0);
        end
      end else begin
        chk("rnd_valid_idle", 64'(rsp_valid[0]), 64'd0);
        g = -1;
        for (int k = 1; k <= int'(NREQ); k++) begin
          if (g < 0 && pend[(ptr + k) % int'(NREQ)]) g = (ptr + k) % int'(NREQ);
        end
        if (g >= 0) begin
          exp_ready[g] = 1'b1;
          exp_id   = g;
          exp_data = alu_f(mop[g], ma[g], mb[g]);
          ptr      = g;
          pend[g]  = 1'b0;
          waiting  = 1'b1;
          rsp_at   = cyc + 3;
        end
      end
      chk("rnd_ready", 64'(req_ready[0]), 64'(exp_ready));
      tick();
    end
    idle_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
